sr_flag_arbiter: RTL



---
 rtl/sr_flag_arbiter_if.sv | 36 +++
 rtl/sr_flag_arbiter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/sr_flag_arbiter_if.sv
// Bundle of requester-side and flag-bank signals for sr_flag_arbiter.
//   req   : per-requester request, held until ack
//   s, r  : per-requester set / reset command bits
//   idx   : per-requester flag index, requester i uses [i*IW +: IW]
//   grant : one-hot, requester currently being serviced
//   ack   : one-hot, one-cycle completion pulse
//   err   : one-cycle pulse with ack when the command was rejected
//   busy  : arbiter is not idle
//   q     : flag bank contents
// The master modport is the requester side, the slave modport is the arbiter.
interface sr_flag_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned NFLAG = 8
);
  localparam int unsigned IW = (NFLAG > 1) ? $clog2(NFLAG) : 1;

  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    s;
  logic [NREQ-1:0]    r;
  logic [NREQ*IW-1:0] idx;
  logic [NREQ-1:0]    grant;
  logic [NREQ-1:0]    ack;
  logic               err;
  logic               busy;
  logic [NFLAG-1:0]   q;

  modport master (
    output req, s, r, idx,
    input  grant, ack, err, busy, q
  );

  modport slave (
    input  req, s, r, idx,
    output grant, ack, err, busy, q
  );
endinterface

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter sharing a bank of SR flag bits between NREQ requesters.
// Each transaction takes three cycles: arbitrate (IDLE), apply (EXEC), retire (ACK).
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-high reset; drops any in-flight command, clears q
//   bus : sr_flag_arbiter_if slave modport (req/s/r/idx in, grant/ack/err/busy/q out)
// The S=R=1 command and any index beyond the bank are rejected with err instead of
// touching the flags. All outputs are registered.
module sr_flag_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned NFLAG = 8
) (
  input logic              clk,
  input logic              rst,
  sr_flag_arbiter_if.slave bus
);
  localparam int unsigned IW = (NFLAG > 1) ? $clog2(NFLAG) : 1;
  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {StIdle, StExec, StAck} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    win_q, win_d;
  logic             s_q, s_d;
  logic             r_q, r_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic [NFLAG-1:0] q_q, q_d;

  logic             found;
  logic [PW-1:0]    pick;
  logic             idx_ok;

  // First requester at or after ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!found && bus.req[PW'((32'(ptr_q) + k) % NREQ)]) begin
        found = 1'b1;
        pick  = PW'((32'(ptr_q) + k) % NREQ);
      end
    end
  end

  // Only matters when NFLAG is not a power of two.
  always_comb idx_ok = (32'(idx_q) < NFLAG);

  // State register and all datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      win_q   <= '0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      idx_q   <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      s_q     <= s_d;
      r_q     <= r_d;
      idx_q   <= idx_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      q_q     <= q_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (found) state_d = StExec;
      StExec:  state_d = StAck;
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs and captured command.
  always_comb begin
    ptr_d   = ptr_q;
    win_d   = win_q;
    s_d     = s_q;
    r_d     = r_q;
    idx_d   = idx_q;
    grant_d = grant_q;
    ack_d   = ack_q;
    err_d   = err_q;
    busy_d  = busy_q;
    q_d     = q_q;
    case (state_q)
      StIdle: begin
        if (found) begin
          // Capture now so later changes on the bus cannot affect this command.
          win_d   = pick;
          s_d     = bus.s[pick];
          r_d     = bus.r[pick];
          idx_d   = bus.idx[32'(pick)*IW +: IW];
          grant_d = NREQ'(1) << pick;
          busy_d  = 1'b1;
        end
      end
      StExec: begin
        ack_d   = grant_q;
        grant_d = '0;
        err_d   = !idx_ok || (s_q && r_q);
        if (idx_ok && (s_q ^ r_q)) q_d[idx_q] = s_q;
        ptr_d   = (win_q == PW'(NREQ - 1)) ? '0 : win_q + PW'(1);
      end
      StAck: begin
        ack_d  = '0;
        err_d  = 1'b0;
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign bus.grant = grant_q;
  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.busy  = busy_q;
  assign bus.q     = q_q;
endmodule
